// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_pkg
// Description : Shared frame geometry for the NTT permutation stages.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;
    localparam int N      = 1024;
    localparam int LANES  = 32;
    localparam int BEATS  = N / LANES;
    localparam int BEAT_W = $clog2(BEATS);

    typedef logic [BEAT_W-1:0] beat_t;
endpackage
`default_nettype wire

// File: rtl/frame_bank.sv
`default_nettype none
// ============================================================================
// Module      : frame_bank
// Description : BEATS x LANES word array, written a row at a time and read
//               a column at a time (the transpose happens across the ports).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_bank
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             wr_en,
    input  beat_t                            wr_row,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] wr_data,
    input  beat_t                            rd_col,
    output logic [BEATS-1:0][DATA_WIDTH-1:0] rd_data
);

    logic [BEATS-1:0][LANES-1:0][DATA_WIDTH-1:0] r_mem;

    // Storage carries no reset; a frame is always fully written before read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_row] <= wr_data;
        end
    end

    genvar r;
    generate
        for (r = 0; r < BEATS; r++) begin : g_col
            assign rd_data[r] = r_mem[r][rd_col];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/stage_2_temporal_permutation.sv
`default_nettype none
// ============================================================================
// Module      : stage_2_temporal_permutation
// Description : Ping-pong 32x32 transpose; a frame captured over 32 beats is
//               replayed column-wise starting 32 cycles after its inStart.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_2_temporal_permutation
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = 32,
    parameter int INPUT_PER_CYCLE      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            inStart,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_0,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_1,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_2,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_3,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_4,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_5,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_6,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_7,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_8,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_9,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_10,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_11,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_12,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_13,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_14,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_15,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_16,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_17,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_18,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_19,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_20,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_21,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_22,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_23,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_24,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_25,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_26,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_27,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_28,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_29,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_30,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_31,
    output logic                            outStart,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_0,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_1,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_2,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_3,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_4,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_5,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_6,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_7,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_8,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_9,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_10,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_11,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_12,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_13,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_14,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_15,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_16,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_17,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_18,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_19,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_20,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_21,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_22,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_23,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_24,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_25,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_26,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_27,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_28,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_29,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_30,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_31
);

    localparam int W = DATA_WIDTH_PER_INPUT;

    logic [INPUT_PER_CYCLE-1:0][W-1:0] w_in_row;
    logic [INPUT_PER_CYCLE-1:0][W-1:0] r_out_data;
    logic [1:0][BEATS-1:0][W-1:0]      w_rd_data;

    logic  r_wr_bank;
    logic  r_in_active;
    logic  r_out_active;
    logic  r_out_start;
    beat_t r_in_beat;
    beat_t r_out_beat;
    beat_t w_beat;
    logic  w_write;
    logic  w_last;
    logic  w_rd_bank;

    assign w_in_row[0]  = inData_0;
    assign w_in_row[1]  = inData_1;
    assign w_in_row[2]  = inData_2;
    assign w_in_row[3]  = inData_3;
    assign w_in_row[4]  = inData_4;
    assign w_in_row[5]  = inData_5;
    assign w_in_row[6]  = inData_6;
    assign w_in_row[7]  = inData_7;
    assign w_in_row[8]  = inData_8;
    assign w_in_row[9]  = inData_9;
    assign w_in_row[10] = inData_10;
    assign w_in_row[11] = inData_11;
    assign w_in_row[12] = inData_12;
    assign w_in_row[13] = inData_13;
    assign w_in_row[14] = inData_14;
    assign w_in_row[15] = inData_15;
    assign w_in_row[16] = inData_16;
    assign w_in_row[17] = inData_17;
    assign w_in_row[18] = inData_18;
    assign w_in_row[19] = inData_19;
    assign w_in_row[20] = inData_20;
    assign w_in_row[21] = inData_21;
    assign w_in_row[22] = inData_22;
    assign w_in_row[23] = inData_23;
    assign w_in_row[24] = inData_24;
    assign w_in_row[25] = inData_25;
    assign w_in_row[26] = inData_26;
    assign w_in_row[27] = inData_27;
    assign w_in_row[28] = inData_28;
    assign w_in_row[29] = inData_29;
    assign w_in_row[30] = inData_30;
    assign w_in_row[31] = inData_31;

    // An inStart always forces beat 0, which also restarts a partial frame.
    assign w_write   = inStart | r_in_active;
    assign w_beat    = inStart ? '0 : r_in_beat;
    assign w_last    = w_write && (w_beat == beat_t'(BEATS - 1));
    assign w_rd_bank = ~r_wr_bank;

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_bank
            frame_bank #(
                .DATA_WIDTH (W)
            ) u_bank (
                .clk     (clk),
                .wr_en   (w_write && (r_wr_bank == 1'(b))),
                .wr_row  (w_beat),
                .wr_data (w_in_row),
                .rd_col  (r_out_beat),
                .rd_data (w_rd_data[b])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_active <= 1'b0;
            r_in_beat   <= '0;
            r_wr_bank   <= 1'b0;
        end else if (w_write) begin
            if (w_last) begin
                r_in_active <= 1'b0;
                r_in_beat   <= '0;
                r_wr_bank   <= ~r_wr_bank;
            end else begin
                r_in_active <= 1'b1;
                r_in_beat   <= w_beat + beat_t'(1);
            end
        end
    end

    // Arming on the last input beat wins over the end of the current output
    // frame, so back-to-back frames replay without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_active <= 1'b0;
            r_out_beat   <= '0;
            r_out_start  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            if (r_out_active) begin
                r_out_data  <= w_rd_data[w_rd_bank];
                r_out_start <= (r_out_beat == '0);
                r_out_beat  <= r_out_beat + beat_t'(1);
            end else begin
                r_out_data  <= '0;
                r_out_start <= 1'b0;
            end
            if (w_last) begin
                r_out_active <= 1'b1;
                r_out_beat   <= '0;
            end else if (r_out_active && (r_out_beat == beat_t'(BEATS - 1))) begin
                r_out_active <= 1'b0;
            end
        end
    end

    assign outStart   = r_out_start;
    assign outData_0  = r_out_data[0];
    assign outData_1  = r_out_data[1];
    assign outData_2  = r_out_data[2];
    assign outData_3  = r_out_data[3];
    assign outData_4  = r_out_data[4];
    assign outData_5  = r_out_data[5];
    assign outData_6  = r_out_data[6];
    assign outData_7  = r_out_data[7];
    assign outData_8  = r_out_data[8];
    assign outData_9  = r_out_data[9];
    assign outData_10 = r_out_data[10];
    assign outData_11 = r_out_data[11];
    assign outData_12 = r_out_data[12];
    assign outData_13 = r_out_data[13];
    assign outData_14 = r_out_data[14];
    assign outData_15 = r_out_data[15];
    assign outData_16 = r_out_data[16];
    assign outData_17 = r_out_data[17];
    assign outData_18 = r_out_data[18];
    assign outData_19 = r_out_data[19];
    assign outData_20 = r_out_data[20];
    assign outData_21 = r_out_data[21];
    assign outData_22 = r_out_data[22];
    assign outData_23 = r_out_data[23];
    assign outData_24 = r_out_data[24];
    assign outData_25 = r_out_data[25];
    assign outData_26 = r_out_data[26];
    assign outData_27 = r_out_data[27];
    assign outData_28 = r_out_data[28];
    assign outData_29 = r_out_data[29];
    assign outData_30 = r_out_data[30];
    assign outData_31 = r_out_data[31];

endmodule
`default_nettype wire

// File: tb/tb_stage_2_temporal_permutation.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_2_temporal_permutation
// Description : Self-checking bench: directed frames plus a randomized
//               frame stream checked against a scheduled-transpose model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_2_temporal_permutation;

    localparam int L    = 32;
    localparam int MAXC = 4096;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        in_start = 1'b0;
    logic [31:0] in_data  [L];
    logic [31:0] out_data [L];
    logic        out_start;

    always #5 clk = ~clk;

    stage_2_temporal_permutation dut (
        .clk (clk), .rst (rst), .inStart (in_start),
        .inData_0 (in_data[0]),   .inData_1 (in_data[1]),   .inData_2 (in_data[2]),   .inData_3 (in_data[3]),
        .inData_4 (in_data[4]),   .inData_5 (in_data[5]),   .inData_6 (in_data[6]),   .inData_7 (in_data[7]),
        .inData_8 (in_data[8]),   .inData_9 (in_data[9]),   .inData_10(in_data[10]),  .inData_11(in_data[11]),
        .inData_12(in_data[12]),  .inData_13(in_data[13]),  .inData_14(in_data[14]),  .inData_15(in_data[15]),
        .inData_16(in_data[16]),  .inData_17(in_data[17]),  .inData_18(in_data[18]),  .inData_19(in_data[19]),
        .inData_20(in_data[20]),  .inData_21(in_data[21]),  .inData_22(in_data[22]),  .inData_23(in_data[23]),
        .inData_24(in_data[24]),  .inData_25(in_data[25]),  .inData_26(in_data[26]),  .inData_27(in_data[27]),
        .inData_28(in_data[28]),  .inData_29(in_data[29]),  .inData_30(in_data[30]),  .inData_31(in_data[31]),
        .outStart (out_start),
        .outData_0 (out_data[0]),  .outData_1 (out_data[1]),  .outData_2 (out_data[2]),  .outData_3 (out_data[3]),
        .outData_4 (out_data[4]),  .outData_5 (out_data[5]),  .outData_6 (out_data[6]),  .outData_7 (out_data[7]),
        .outData_8 (out_data[8]),  .outData_9 (out_data[9]),  .outData_10(out_data[10]), .outData_11(out_data[11]),
        .outData_12(out_data[12]), .outData_13(out_data[13]), .outData_14(out_data[14]), .outData_15(out_data[15]),
        .outData_16(out_data[16]), .outData_17(out_data[17]), .outData_18(out_data[18]), .outData_19(out_data[19]),
        .outData_20(out_data[20]), .outData_21(out_data[21]), .outData_22(out_data[22]), .outData_23(out_data[23]),
        .outData_24(out_data[24]), .outData_25(out_data[25]), .outData_26(out_data[26]), .outData_27(out_data[27]),
        .outData_28(out_data[28]), .outData_29(out_data[29]), .outData_30(out_data[30]), .outData_31(out_data[31])
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Expected output per cycle; cycle n is the value visible after edge n.
    logic        exp_s [MAXC];
    logic [31:0] exp_d [MAXC][L];

    logic [31:0] m_frame [L][L];
    bit          m_active;
    int          m_cnt;

    int          os_count;
    int          os_first;
    int          os_last;
    int          cap_base = -1;
    logic [31:0] cap [L][L];

    typedef struct {
        int          c;
        int          l;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < MAXC; n++) begin
            exp_s[n] = 1'b0;
            for (int l = 0; l < L; l++) exp_d[n][l] = '0;
        end
        m_active = 1'b0;
        m_cnt    = 0;
        cyc      = 0;
    endtask

    // A completed frame schedules its transpose for the 32 following cycles.
    task automatic model_capture();
        if (in_start) begin
            m_active = 1'b1;
            m_cnt    = 0;
        end
        if (m_active) begin
            for (int l = 0; l < L; l++) m_frame[m_cnt][l] = in_data[l];
            m_cnt++;
            if (m_cnt == L) begin
                m_active = 1'b0;
                m_cnt    = 0;
                if (cyc + 1 + L < MAXC) begin
                    exp_s[cyc + 1] = 1'b1;
                    for (int c = 0; c < L; c++)
                        for (int l = 0; l < L; l++)
                            exp_d[cyc + 1 + c][l] = m_frame[l][c];
                end
            end
        end
    endtask

    task automatic tick();
        int li;
        if (rst) model_capture();
        @(posedge clk);
        #1;
        li = 0;
        for (int l = L - 1; l >= 0; l--)
            if (out_data[l] !== exp_d[cyc][l]) li = l;
        check("outStart", {31'b0, out_start}, {31'b0, exp_s[cyc]});
        check($sformatf("outData_%0d", li), out_data[li], exp_d[cyc][li]);
        if (out_start === 1'b1) begin
            os_count++;
            if (os_first < 0) os_first = cyc;
            os_last = cyc;
        end
        if (cap_base >= 0 && cyc >= cap_base && cyc < cap_base + L)
            for (int l = 0; l < L; l++) cap[cyc - cap_base][l] = out_data[l];
        cyc++;
    endtask

    task automatic set_idle_random();
        in_start = 1'b0;
        for (int l = 0; l < L; l++) in_data[l] = $urandom();
    endtask

    task automatic set_beat(input bit st, input int b, input int off);
        in_start = st;
        for (int l = 0; l < L; l++) in_data[l] = 32'(32 * b + l + off);
    endtask

    task automatic set_beat_random(input bit st);
        in_start = st;
        for (int l = 0; l < L; l++) in_data[l] = $urandom();
    endtask

    task automatic clear_stats();
        os_count = 0;
        os_first = -1;
        os_last  = -1;
    endtask

    // Asserted between edges so the asynchronous clear is observable at once.
    task automatic do_reset();
        logic [31:0] orv;
        rst = 1'b0;
        #1;
        orv = '0;
        for (int l = 0; l < L; l++) orv = orv | out_data[l];
        check("reset_outStart", {31'b0, out_start}, 32'd0);
        check("reset_outData", orv, 32'd0);
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        model_reset();
        clear_stats();
    endtask

    initial begin
        int s;
        int restart_at;
        bit restarted;

        tbl[0] = '{c: 1,  l: 2,  exp: 32'd65};
        tbl[1] = '{c: 0,  l: 0,  exp: 32'd0};
        tbl[2] = '{c: 0,  l: 31, exp: 32'd992};
        tbl[3] = '{c: 31, l: 0,  exp: 32'd31};
        tbl[4] = '{c: 31, l: 31, exp: 32'd1023};
        tbl[5] = '{c: 5,  l: 7,  exp: 32'd229};
        tbl[6] = '{c: 16, l: 10, exp: 32'd336};
        tbl[7] = '{c: 3,  l: 30, exp: 32'd963};

        set_idle_random();
        #2;

        // Single frame, inStart at cycle 10
        do_reset();
        while (cyc < 10) begin set_idle_random(); tick(); end
        cap_base = 42;
        for (int b = 0; b < L; b++) begin set_beat(b == 0, b, 0); tick(); end
        repeat (40) begin set_idle_random(); tick(); end
        cap_base = -1;
        check("s1_outStart_cycle", 32'(os_first), 32'd42);
        check("s1_outStart_count", 32'(os_count), 32'd1);
        for (int t = 0; t < 8; t++)
            check($sformatf("s1_c%0d_l%0d", tbl[t].c, tbl[t].l), cap[tbl[t].c][tbl[t].l], tbl[t].exp);

        // Three back-to-back tagged frames
        do_reset();
        repeat (3) begin set_idle_random(); tick(); end
        s = cyc;
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < L; b++) begin set_beat(b == 0, b, 4096 * f); tick(); end
        repeat (40) begin set_idle_random(); tick(); end
        check("s2_outStart_count", 32'(os_count), 32'd3);
        check("s2_first_latency", 32'(os_first - s), 32'd32);
        check("s2_span", 32'(os_last - os_first), 32'd64);

        // Restart at beat 12
        do_reset();
        repeat (5) begin set_idle_random(); tick(); end
        for (int b = 0; b < 12; b++) begin set_beat_random(b == 0); tick(); end
        s = cyc;
        for (int b = 0; b < L; b++) begin set_beat_random(b == 0); tick(); end
        repeat (40) begin set_idle_random(); tick(); end
        check("s3_outStart_count", 32'(os_count), 32'd1);
        check("s3_latency", 32'(os_first - s), 32'd32);

        // Reset at output beat 5
        do_reset();
        repeat (2) begin set_idle_random(); tick(); end
        s = cyc;
        for (int b = 0; b < L; b++) begin set_beat_random(b == 0); tick(); end
        while (cyc <= s + 37) begin set_idle_random(); tick(); end
        check("s4_beat5_reached", 32'(os_first - s), 32'd32);
        do_reset();
        repeat (60) begin set_idle_random(); tick(); end
        check("s4_no_output_after_reset", 32'(os_count), 32'd0);

        // Data without inStart is ignored
        do_reset();
        repeat (100) begin set_idle_random(); tick(); end
        check("s5_no_outStart", 32'(os_count), 32'd0);

        // Randomized frame stream with gaps and restarts
        do_reset();
        for (int f = 0; f < 20; f++) begin
            repeat ($urandom_range(0, 3)) begin set_idle_random(); tick(); end
            restart_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 0;
            restarted  = 1'b0;
            for (int b = 0; b < L; b++) begin
                set_beat_random(b == 0);
                tick();
                if (!restarted && restart_at > 0 && b + 1 == restart_at) begin
                    restarted = 1'b1;
                    b = -1;
                end
            end
        end
        repeat (40) begin set_idle_random(); tick(); end
        check("s6_outStart_count", 32'(os_count), 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
